// File: rtl/axis_job_sender_pkg.sv
// Shared definitions for the job sender: the FSM state encoding, the
// default miner stream constants and a constant-foldable clog2 helper.
package axis_job_sender_pkg;

   // Miner stream defaults used as parameter defaults by the sender
   localparam int MINER_TDATA_WIDTH  = 32;
   localparam int MINER_START_COUNT  = 32;
   localparam int MINER_OUTPUT_WORDS = 8;

   typedef enum logic [1:0] {
      ST_INIT_WAIT = 2'd0,
      ST_IDLE      = 2'd1,
      ST_SEND      = 2'd2
   } job_state_e;

   // Number of bits needed to index 'value' distinct items
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axis_job_sender.sv
// AXI4-Stream job sender: after a start-up quiet period, transmits words
// 0..len-1 of a small locally written buffer as one packet per start pulse.
module axis_job_sender
   import axis_job_sender_pkg::*;
#(
   parameter int C_M_AXIS_TDATA_WIDTH   = MINER_TDATA_WIDTH,
   parameter int C_M_START_COUNT        = MINER_START_COUNT,
   parameter int NUMBER_OF_OUTPUT_WORDS = MINER_OUTPUT_WORDS,
   localparam int AW = clog2(NUMBER_OF_OUTPUT_WORDS)
) (
   input  logic                              M_AXIS_ACLK,
   input  logic                              M_AXIS_ARESETN,
   input  logic                              wr_en,
   input  logic [AW-1:0]                     wr_addr,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   wr_data,
   input  logic [AW:0]                       pkt_len,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY
);

   localparam int CW = clog2(C_M_START_COUNT + 1);
   localparam logic [AW:0]   MAX_LEN    = (AW+1)'(NUMBER_OF_OUTPUT_WORDS);
   localparam logic [CW-1:0] COUNT_LAST = CW'(C_M_START_COUNT - 1);

   job_state_e                      state_r, state_s;
   logic [CW-1:0]                   count_r, count_s;
   logic [AW-1:0]                   rd_ptr_r, rd_ptr_s;
   logic [AW:0]                     len_r, len_s;
   logic                            done_r, done_s;
   logic [AW:0]                     eff_len_s;
   logic                            last_s;
   logic                            send_s;
   logic [C_M_AXIS_TDATA_WIDTH-1:0] buffer_r [0:NUMBER_OF_OUTPUT_WORDS-1];

   // Effective packet length, current-beat-is-last flag and send qualifier
   always_comb begin
      if ((pkt_len == {(AW+1){1'b0}}) || (pkt_len > MAX_LEN)) begin
         eff_len_s = MAX_LEN;
      end else begin
         eff_len_s = pkt_len;
      end
      send_s = (state_r == ST_SEND);
      last_s = ({1'b0, rd_ptr_r} == (len_r - {{AW{1'b0}}, 1'b1}));
   end

   // Next-state logic: start-up counter, start capture and beat advance
   always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      rd_ptr_s = rd_ptr_r;
      len_s    = len_r;
      done_s   = 1'b0;
      case (state_r)
         ST_INIT_WAIT: begin
            if (count_r == COUNT_LAST) begin
               state_s = ST_IDLE;
               count_s = {CW{1'b0}};
            end else begin
               count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_IDLE: begin
            if (start) begin
               len_s    = eff_len_s;
               rd_ptr_s = {AW{1'b0}};
               state_s  = ST_SEND;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (M_AXIS_TREADY) begin
               if (last_s) begin
                  state_s  = ST_IDLE;
                  rd_ptr_s = {AW{1'b0}};
                  done_s   = 1'b1;
               end else begin
                  rd_ptr_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
               end
            end else begin
               state_s = ST_SEND;
            end
         end
         default: begin
            state_s  = ST_INIT_WAIT;
            count_s  = {CW{1'b0}};
            rd_ptr_s = {AW{1'b0}};
            len_s    = {(AW+1){1'b0}};
         end
      endcase
   end

   // Control registers; reset restarts the full start-up wait
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         state_r  <= ST_INIT_WAIT;
         count_r  <= {CW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         len_r    <= {(AW+1){1'b0}};
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         count_r  <= count_s;
         rd_ptr_r <= rd_ptr_s;
         len_r    <= len_s;
         done_r   <= done_s;
      end
   end

   // Buffer write port, open only while idle; contents survive reset
   always_ff @(posedge M_AXIS_ACLK) begin
      if (wr_en && (state_r == ST_IDLE)) begin
         buffer_r[wr_addr] <= wr_data;
      end
   end

   assign busy          = (state_r != ST_IDLE);
   assign done          = done_r;
   assign M_AXIS_TVALID = send_s;
   assign M_AXIS_TLAST  = send_s && last_s;
   assign M_AXIS_TDATA  = send_s ? buffer_r[rd_ptr_r] : {C_M_AXIS_TDATA_WIDTH{1'b0}};
   assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};

endmodule

// File: tb/tb_axis_job_sender.sv
// Directed bench for axis_job_sender with default parameters (32/32/8).
module tb_axis_job_sender;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = 3'd0;
   logic [31:0] wr_data = 32'd0;
   logic [3:0]  pkt_len = 4'd0;
   logic        start = 1'b0;
   logic        tready = 1'b0;
   logic        busy, done, tvalid, tlast;
   logic [31:0] tdata;
   logic [3:0]  tstrb;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_w [0:7];

   axis_job_sender dut (
      .M_AXIS_ACLK    (clk),
      .M_AXIS_ARESETN (rst_n),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .pkt_len        (pkt_len),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .M_AXIS_TVALID  (tvalid),
      .M_AXIS_TDATA   (tdata),
      .M_AXIS_TSTRB   (tstrb),
      .M_AXIS_TLAST   (tlast),
      .M_AXIS_TREADY  (tready)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_buffer();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_addr = 3'(i); wr_data = exp_w[i];
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      int waited;
      #2 rst_n = 1'b0;
      tick(); tick();
      tests++;
      if ({tvalid, tlast, busy, done} !== 4'b0010 || tdata !== 32'd0) begin
         fails++;
         $display("FAIL reset_outputs: got v/l/b/d=%b%b%b%b data=%h, want 0010 data=0", tvalid, tlast, busy, done, tdata);
      end
      tests++;
      if (tstrb !== 4'hF) begin
         fails++; $display("FAIL tstrb: got %h want f", tstrb);
      end
      rst_n = 1'b1; start = 1'b1; pkt_len = 4'd0;
      for (int c = 0; c < 32; c++) begin
         tests++;
         if (busy !== 1'b1 || tvalid !== 1'b0) begin
            fails++; $display("FAIL init_wait c=%0d: got busy=%b tvalid=%b want 1 0", c, busy, tvalid);
         end
         tick();
      end
      tests++;
      if (busy !== 1'b0 || tvalid !== 1'b0) begin
         fails++; $display("FAIL init_to_idle: got busy=%b tvalid=%b want 0 0", busy, tvalid);
      end
      tick();
      start = 1'b0; tready = 1'b1;
      tests++;
      if (busy !== 1'b1 || tvalid !== 1'b1) begin
         fails++; $display("FAIL first_start: got busy=%b tvalid=%b want 1 1", busy, tvalid);
      end
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
         tick(); waited++;
      end
      tests++;
      if (waited != 8) begin
         fails++; $display("FAIL first_drain: got %0d cycles to done, want 8", waited);
      end
   endtask

   task automatic test_full_packet();
      logic exp_last;
      write_buffer();
      pkt_len = 4'd0; start = 1'b1; tready = 1'b1;
      tick();
      start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         exp_last = (b == 7);
         tests++;
         if (tvalid !== 1'b1 || tdata !== exp_w[b] || tlast !== exp_last) begin
            fails++; $display("FAIL full_beat%0d: got v=%b d=%h l=%b want 1 %h %b", b, tvalid, tdata, tlast, exp_w[b], exp_last);
         end
         tick();
      end
      tests++;
      if ({tvalid, tlast, busy, done} !== 4'b0001 || tdata !== 32'd0) begin
         fails++; $display("FAIL full_end: got v/l/b/d=%b%b%b%b data=%h want 0001 data=0", tvalid, tlast, busy, done, tdata);
      end
      tick();
      tests++;
      if (done !== 1'b0) begin
         fails++; $display("FAIL done_pulse: got done=%b want 0", done);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] pat;
      logic       exp_last;
      int         b;
      pat = 4'b1001;
      b = 0;
      pkt_len = 4'd8; start = 1'b1; tready = 1'b0;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40 && b < 8; c++) begin
         tready = pat[c % 4];
         exp_last = (b == 7);
         tests++;
         if (tvalid !== 1'b1 || tdata !== exp_w[b] || tlast !== exp_last) begin
            fails++; $display("FAIL bp_c%0d_beat%0d: got v=%b d=%h l=%b want 1 %h %b", c, b, tvalid, tdata, tlast, exp_w[b], exp_last);
         end
         if (tready) b++;
         tick();
      end
      tready = 1'b1;
      tests++;
      if (b != 8 || done !== 1'b1 || tvalid !== 1'b0) begin
         fails++; $display("FAIL bp_end: got beats=%0d done=%b tvalid=%b want 8 1 0", b, done, tvalid);
      end
   endtask

   task automatic test_short_packet();
      logic exp_last;
      int   n;
      pkt_len = 4'd3; start = 1'b1; tready = 1'b1;
      tick();
      start = 1'b0;
      for (int b = 0; b < 3; b++) begin
         if (b == 1) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFF_FFFF; start = 1'b1; pkt_len = 4'd0;
         end
         exp_last = (b == 2);
         tests++;
         if (tvalid !== 1'b1 || tdata !== exp_w[b] || tlast !== exp_last) begin
            fails++; $display("FAIL short_beat%0d: got v=%b d=%h l=%b want 1 %h %b", b, tvalid, tdata, tlast, exp_w[b], exp_last);
         end
         tick();
      end
      wr_en = 1'b0; start = 1'b0;
      tests++;
      if (done !== 1'b1 || tvalid !== 1'b0) begin
         fails++; $display("FAIL short_end: got done=%b tvalid=%b want 1 0", done, tvalid);
      end
      tick();
      pkt_len = 4'd12; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         if (tvalid === 1'b1) begin
            exp_last = (n == 7);
            tests++;
            if (n >= 8 || tdata !== exp_w[n] || tlast !== exp_last) begin
               fails++; $display("FAIL overlen_beat%0d: got d=%h l=%b want %h %b", n, tdata, tlast, exp_w[n % 8], exp_last);
            end
            n++;
         end
         tick();
         if (done === 1'b1) break;
      end
      tests++;
      if (n != 8 || done !== 1'b1) begin
         fails++; $display("FAIL overlen_count: got beats=%0d done=%b want 8 1", n, done);
      end
   endtask

   task automatic test_reset_mid();
      logic exp_last;
      pkt_len = 4'd0; start = 1'b1; tready = 1'b1;
      tick();
      start = 1'b0;
      for (int b = 0; b < 4; b++) tick();
      tests++;
      if (tvalid !== 1'b1 || tdata !== exp_w[4]) begin
         fails++; $display("FAIL mid_beat4: got v=%b d=%h want 1 %h", tvalid, tdata, exp_w[4]);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({tvalid, tlast, busy, done} !== 4'b0010 || tdata !== 32'd0) begin
         fails++; $display("FAIL mid_reset: got v/l/b/d=%b%b%b%b data=%h want 0010 data=0", tvalid, tlast, busy, done, tdata);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 32; c++) begin
         tests++;
         if (busy !== 1'b1 || tvalid !== 1'b0) begin
            fails++; $display("FAIL reinit c=%0d: got busy=%b tvalid=%b want 1 0", c, busy, tvalid);
         end
         tick();
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL reinit_idle: got busy=%b want 0", busy);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         exp_last = (b == 7);
         tests++;
         if (tvalid !== 1'b1 || tdata !== exp_w[b] || tlast !== exp_last) begin
            fails++; $display("FAIL resend_beat%0d: got v=%b d=%h l=%b want 1 %h %b", b, tvalid, tdata, tlast, exp_w[b], exp_last);
         end
         tick();
      end
      tests++;
      if (done !== 1'b1) begin
         fails++; $display("FAIL resend_done: got %b want 1", done);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] seq [0:4];
      logic        exp_last;
      seq[0] = 32'h0000_DEAD; seq[1] = 32'h22;
      seq[2] = 32'h0000_DEAD; seq[3] = 32'h22; seq[4] = 32'h33;
      tick();
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h0000_DEAD;
      pkt_len = 4'd2; start = 1'b1; tready = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_last = (i == 1) || (i == 4);
         tests++;
         if (tvalid !== 1'b1 || tdata !== seq[i] || tlast !== exp_last) begin
            fails++; $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b want 1 %h %b", i, tvalid, tdata, tlast, seq[i], exp_last);
         end
         tick();
         if (i == 1) begin
            tests++;
            if (done !== 1'b1 || busy !== 1'b0) begin
               fails++; $display("FAIL b2b_done1: got done=%b busy=%b want 1 0", done, busy);
            end
            start = 1'b1; pkt_len = 4'd3;
            tick();
            start = 1'b0;
         end
      end
      tests++;
      if (done !== 1'b1 || tvalid !== 1'b0) begin
         fails++; $display("FAIL b2b_done2: got done=%b tvalid=%b want 1 0", done, tvalid);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) exp_w[i] = 32'h11 * (i + 1);
      test_reset();
      test_full_packet();
      test_backpressure();
      test_short_packet();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axis_job_sender.md
AXIS_JOB_SENDER -- requirements
Module: axis_job_sender

Interface
REQ-001 Parameter C_M_AXIS_TDATA_WIDTH, default 32: stream data width in bits.
REQ-002 Parameter C_M_START_COUNT, default 32: clock cycles to wait after reset release before any transfer.
REQ-003 Parameter NUMBER_OF_OUTPUT_WORDS, default 8: buffer depth and maximum packet length; AW = clog2(NUMBER_OF_OUTPUT_WORDS).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 M_AXIS_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-006 M_AXIS_ARESETN  in  1  asynchronous active-low reset.
REQ-007 wr_en  in  1  buffer write strobe.
REQ-008 wr_addr  in  AW  buffer word index.
REQ-009 wr_data  in  C_M_AXIS_TDATA_WIDTH  word to store.
REQ-010 pkt_len  in  AW+1  beats to send, sampled on start; 0 or >NUMBER_OF_OUTPUT_WORDS means NUMBER_OF_OUTPUT_WORDS.
REQ-011 start  in  1  one-cycle request to transmit buffer words 0..len-1.
REQ-012 busy  out  1  high in INIT_WAIT and SEND.
REQ-013 done  out  1  one-cycle pulse after the last beat is accepted.
REQ-014 M_AXIS_TVALID  out  1; M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH; M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8, constant all-ones; M_AXIS_TLAST  out  1; M_AXIS_TREADY  in  1.

Function
REQ-015 States SHALL be INIT_WAIT, IDLE, SEND.
REQ-016 INIT_WAIT: counter increments each cycle; after C_M_START_COUNT cycles, go to IDLE.
REQ-017 IDLE: start=1 captures effective length into len_q, clears rd_ptr, goes to SEND next cycle.
REQ-018 wr_en SHALL write buffer[wr_addr] only in IDLE; writes in INIT_WAIT/SEND are dropped.
REQ-019 wr_en and start in the same IDLE cycle: the written word SHALL be part of the packet.
REQ-020 start outside IDLE SHALL be ignored, not queued.
REQ-021 SEND: TVALID=1, TDATA=buffer[rd_ptr], TLAST=(rd_ptr==len_q-1).
REQ-022 A beat transfers when TVALID&&TREADY; rd_ptr then increments. Without TREADY, TDATA/TLAST stay stable and TVALID stays high.
REQ-023 Latency: start at cycle k, beat 0 valid at k+1; with TREADY held high, one beat per cycle, no bubbles.
REQ-024 Last beat accepted at cycle j: at j+1 TVALID=0, done=1, busy=0, state IDLE; start at j+1 is accepted.
REQ-025 TVALID SHALL never be high outside SEND; TLAST SHALL only be high with TVALID.
REQ-026 rd_ptr SHALL return to 0 on packet end; no wrap past len_q-1.

Reset
REQ-027 Asserting M_AXIS_ARESETN low (including mid-packet) SHALL immediately force TVALID=0, TLAST=0, busy=1, done=0, state INIT_WAIT, rd_ptr=0, counter=0, len_q=0.
REQ-028 TDATA SHALL read 0 while TVALID=0. Buffer contents are not reset.
REQ-029 After release, INIT_WAIT repeats in full.

Structure
REQ-030 State encoding and clog2 SHALL live in the shared package with the miner stream constants.
REQ-031 Single module; buffer inferred as a register array; no sub-modules.

Verification
REQ-032 Reset release, start pulsed every cycle -> busy=1 and no TVALID for 32 cycles; first start accepted in IDLE.
REQ-033 Write 0x11..0x88 to addr 0..7, pkt_len=0, start, TREADY=1 -> 8 consecutive beats 0x11..0x88, TLAST on 0x88, done one cycle later.
REQ-034 Same packet, TREADY toggling 1,0,0,1 -> each beat held stable until accepted, order preserved, TLAST only on 8th.
REQ-035 pkt_len=3 -> beats 0x11,0x22,0x33 with TLAST on 0x33; wr_en/start during SEND change nothing.
REQ-036 Reset asserted after beat 4 -> TVALID low same cycle; after re-init, start resends from word 0 with buffer intact.
REQ-037 wr_en addr0=0xDEAD with start same cycle -> first beat 0xDEAD; start at done cycle -> back-to-back packets.
